// File: rtl/if_fetch_unit.sv
// Purpose : IF-stage fetch unit. Owns the PC, selects the next PC and addresses the synchronous instruction RAM.
// Latency : the IM address is driven from npc, so the IM read data lines up with pc_q one cycle later.
// Backpr. : stall holds the PC and re-presents the same IM address, with no internal buffering.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] IM_BASE   = 32'h0000_3000,  // must be word-aligned
  parameter int          IM_ADDR_W = 11,
  parameter logic [31:0] EXC_VEC   = 32'h0000_4180
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 stall,
  input  logic                 br_taken,
  input  logic [31:0]          br_target,
  input  logic                 exc_req,
  input  logic                 eret_req,
  input  logic [31:0]          epc,
  output logic [IM_ADDR_W-1:0] im_addr,
  input  logic [31:0]          im_data,
  output logic [31:0]          if_pc,
  output logic [31:0]          if_instr,
  output logic                 if_valid,
  output logic                 if_adel
);

  logic [31:0] pc_q, pc_d;
  logic        primed_q, primed_d;
  logic        adel_q, adel_d;

  logic [31:0] npc;
  logic [32:0] im_off;   // npc - IM_BASE with borrow in bit 32
  logic        npc_bad;

  // Next-PC selection. Before the first edge the IM has not yet seen RESET_PC,
  // so the first edge re-presents pc_q instead of advancing.
  always_comb begin
    npc = pc_q + 32'd4;
    if (!primed_q) begin
      npc = pc_q;
    end else if (exc_req) begin
      npc = EXC_VEC;
    end else if (eret_req) begin
      npc = epc;
    end else if (stall) begin
      npc = pc_q;
    end else if (br_taken) begin
      npc = br_target;
    end
  end

  // Address check and IM word address. A borrow (npc below IM_BASE) or any
  // offset bit above the IM window marks the fetch bad; since IM_BASE is
  // word-aligned the low offset bits are exactly npc[1:0].
  always_comb begin
    im_off  = {1'b0, npc} - {1'b0, IM_BASE};
    npc_bad = (im_off[1:0] != 2'b00) || (im_off[32:IM_ADDR_W+2] != '0);
    im_addr = im_off[IM_ADDR_W+1:2];
  end

  // Next-state values for the PC, priming flag and address-error flag.
  always_comb begin
    pc_d     = npc;
    primed_d = 1'b1;
    adel_d   = npc_bad;
  end

  // State registers, asynchronously cleared so outputs drop mid-cycle on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q     <= RESET_PC;
      primed_q <= 1'b0;
      adel_q   <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      primed_q <= primed_d;
      adel_q   <= adel_d;
    end
  end

  // Output bundle. A faulting fetch still presents its PC but never its IM data.
  always_comb begin
    if_pc    = pc_q;
    if_valid = primed_q;
    if_adel  = adel_q & primed_q;
    if_instr = (primed_q && !adel_q) ? im_data : 32'h0;
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, br_taken, exc_req, eret_req;
  logic [31:0] br_target, epc;
  logic [10:0] im_addr;
  logic [31:0] im_data;
  logic [31:0] if_pc, if_instr;
  logic        if_valid, if_adel;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
    .im_addr(im_addr), .im_data(im_data), .if_pc(if_pc), .if_instr(if_instr),
    .if_valid(if_valid), .if_adel(if_adel)
  );

  // Instruction memory: synchronous read, one cycle latency.
  logic [31:0] mem [0:2047];
  always @(posedge clk) im_data <= mem[im_addr];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          stall, br, exc, eret;
    logic [31:0] tgt, epc;
    logic [31:0] e_pc;
    bit          e_valid, e_adel, chk_ia;
    logic [10:0] e_ia;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(bit s, bit b, logic [31:0] t, bit x, bit r, logic [31:0] e,
                              logic [31:0] p, bit v, bit a, bit ci, logic [10:0] ia);
    vec_t r_v;
    r_v.stall = s; r_v.br = b; r_v.tgt = t; r_v.exc = x; r_v.eret = r; r_v.epc = e;
    r_v.e_pc = p; r_v.e_valid = v; r_v.e_adel = a; r_v.chk_ia = ci; r_v.e_ia = ia;
    return r_v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected instruction: the memory word belonging to the presented PC.
  function automatic logic [31:0] exp_instr(logic [31:0] pc, bit v, bit a);
    logic [31:0] w;
    if (!v || a) return 32'h0;
    w = (pc - 32'h3000) / 4;
    return mem[w[10:0]];
  endfunction

  task automatic check_outs(input string tag, input logic [31:0] pc, input bit v, input bit a);
    chk({tag, "_pc"},    if_pc, pc);
    chk({tag, "_valid"}, 32'(if_valid), 32'(v));
    chk({tag, "_adel"},  32'(if_adel), 32'(a));
    chk({tag, "_instr"}, if_instr, exp_instr(pc, v, a));
  endtask

  // Reference model rules.
  function automatic logic [31:0] model_npc(bit primed, logic [31:0] pc, bit s, bit b,
                                            logic [31:0] t, bit x, bit r, logic [31:0] e);
    if (!primed) return pc;
    if (x)       return 32'h0000_4180;
    if (r)       return e;
    if (s)       return pc;
    if (b)       return t;
    return pc + 32'd4;
  endfunction

  function automatic bit model_bad(logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h0000_3000) || (a > 32'h0000_4FFC);
  endfunction

  function automatic logic [31:0] rnd_addr();
    int unsigned r;
    r = $urandom_range(0, 7);
    if (r == 0) return $urandom;
    if (r == 1) return 32'h3000 + (32'($urandom_range(0, 2047)) << 2) + 32'($urandom_range(1, 3));
    return 32'h3000 + (32'($urandom_range(0, 2047)) << 2);
  endfunction

  task automatic clear_inputs();
    stall = 0; br_taken = 0; exc_req = 0; eret_req = 0; br_target = 0; epc = 0;
  endtask

  logic [31:0] m_pc, npc;
  bit          m_primed, m_adel;

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'hC000_0000 ^ (i * 32'h0001_0003);
    mem[0] = 32'h2408_0001;
    mem[1] = 32'h2409_0002;

    // Directed vectors: inputs for the cycle and the outputs expected in it.
    tv.push_back(mk(0,0,0,0,0,0, 32'h3000,0,0,1,11'h000));
    tv.push_back(mk(0,0,0,0,0,0, 32'h3000,1,0,1,11'h001));
    tv.push_back(mk(0,0,0,0,0,0, 32'h3004,1,0,1,11'h002));
    tv.push_back(mk(1,0,0,0,0,0, 32'h3008,1,0,1,11'h002));
    tv.push_back(mk(1,0,0,0,0,0, 32'h3008,1,0,1,11'h002));
    tv.push_back(mk(1,0,0,0,0,0, 32'h3008,1,0,1,11'h002));
    tv.push_back(mk(0,0,0,0,0,0, 32'h3008,1,0,1,11'h003));
    tv.push_back(mk(0,0,0,0,0,0, 32'h300C,1,0,1,11'h004));
    tv.push_back(mk(0,0,0,0,0,0, 32'h3010,1,0,1,11'h005));
    tv.push_back(mk(0,1,32'h3100,0,0,0, 32'h3014,1,0,1,11'h040));
    tv.push_back(mk(1,1,32'h3200,0,0,0, 32'h3100,1,0,1,11'h040));
    tv.push_back(mk(0,0,0,0,0,0, 32'h3100,1,0,1,11'h041));
    tv.push_back(mk(1,0,0,1,1,32'h3020, 32'h3104,1,0,1,11'h460));
    tv.push_back(mk(0,0,0,0,1,32'h3020, 32'h4180,1,0,1,11'h008));
    tv.push_back(mk(0,1,32'h3002,0,0,0, 32'h3020,1,0,0,11'h000));
    tv.push_back(mk(0,0,0,0,0,0, 32'h3002,1,1,0,11'h000));
    tv.push_back(mk(0,1,32'h5000,0,0,0, 32'h3006,1,1,0,11'h000));
    tv.push_back(mk(0,1,32'h4FFC,0,0,0, 32'h5000,1,1,1,11'h7FF));
    tv.push_back(mk(0,1,32'h2FFC,0,0,0, 32'h4FFC,1,0,0,11'h000));
    tv.push_back(mk(0,1,32'h3030,0,0,0, 32'h2FFC,1,1,1,11'h00C));
    tv.push_back(mk(0,1,32'hFFFF_FFFC,0,0,0, 32'h3030,1,0,0,11'h000));
    tv.push_back(mk(0,0,0,0,0,0, 32'hFFFF_FFFC,1,1,0,11'h000));
    tv.push_back(mk(0,1,32'h3038,0,0,0, 32'h0000_0000,1,1,1,11'h00E));
    tv.push_back(mk(0,0,0,0,0,0, 32'h3038,1,0,1,11'h00F));
    tv.push_back(mk(0,0,0,0,0,0, 32'h303C,1,0,1,11'h010));

    // Reset state.
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_outs("rst", 32'h3000, 0, 0);
    chk("rst_im_addr", 32'(im_addr), 32'h0);
    reset_n = 1'b1;

    // Table-driven phase.
    for (int i = 0; i < tv.size(); i++) begin
      stall = tv[i].stall; br_taken = tv[i].br; br_target = tv[i].tgt;
      exc_req = tv[i].exc; eret_req = tv[i].eret; epc = tv[i].epc;
      #1;
      check_outs($sformatf("vec%0d", i), tv[i].e_pc, tv[i].e_valid, tv[i].e_adel);
      if (tv[i].chk_ia) chk($sformatf("vec%0d_im_addr", i), 32'(im_addr), 32'(tv[i].e_ia));
      @(posedge clk);
      #1;
    end
    clear_inputs();

    // Mid-cycle reset at 0x3040, then the priming sequence again.
    check_outs("pre_arst", 32'h3040, 1, 0);
    #2 reset_n = 1'b0;
    #1;
    check_outs("arst", 32'h3000, 0, 0);
    chk("arst_im_addr", 32'(im_addr), 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    check_outs("reprime0", 32'h3000, 0, 0);
    chk("reprime0_im_addr", 32'(im_addr), 32'h0);
    @(posedge clk);
    #1;
    check_outs("reprime1", 32'h3000, 1, 0);
    @(posedge clk);
    #1;
    check_outs("reprime2", 32'h3004, 1, 0);

    // Randomised phase against the reference model.
    m_pc = 32'h3004; m_primed = 1; m_adel = 0;
    for (int c = 0; c < 800; c++) begin
      stall     = ($urandom_range(0, 3) == 0);
      br_taken  = ($urandom_range(0, 3) == 0);
      br_target = rnd_addr();
      exc_req   = ($urandom_range(0, 29) == 0);
      eret_req  = ($urandom_range(0, 19) == 0);
      epc       = rnd_addr();
      #1;
      npc = model_npc(m_primed, m_pc, stall, br_taken, br_target, exc_req, eret_req, epc);
      check_outs("rnd", m_pc, m_primed, m_adel);
      if (!model_bad(npc)) chk("rnd_im_addr", 32'(im_addr), (npc - 32'h3000) / 4);
      if ($urandom_range(0, 99) == 0) begin
        #1 reset_n = 1'b0;
        #1;
        check_outs("rnd_arst", 32'h3000, 0, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        m_pc = 32'h3000; m_primed = 0; m_adel = 0;
      end else begin
        @(posedge clk);
        #1;
        m_pc = npc; m_primed = 1; m_adel = model_bad(npc);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
